cnn_weight_lane_buffer: RTL and testbench

Parametrised local weight store for a CNN layer engine. It accepts a serial stream of DATA_W-bit weights and packs LANES consecutive weights into one DEPTH-deep word store, so a full set of LANES weights can be read per word. Two registered read ports are provided, and port 2 applies a runtime base offset (filter-bank select). It sits between the DMA/weight loader and the layer MAC array, and replaces the fixed 8-lane, 16-bit, 50-word per-layer weight memories.

---
 rtl/cnn_weight_pkg.sv | 21 ++
 rtl/weight_lane_store.sv | 45 ++++
 rtl/cnn_weight_lane_buffer.sv | 127 ++++++++++++
 tb/tb_cnn_weight_lane_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_weight_pkg.sv
// rtl/cnn_weight_pkg.sv - shared types and helpers for the CNN weight lane buffer
package cnn_weight_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } wr_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 8;
  localparam int DEF_DEPTH  = 64;

  // Widest lane count the one-hot helper can express; callers truncate to LANES.
  localparam int MAX_LANES  = 64;

  // One-hot lane write enable for the lane currently being filled.
  function automatic logic [MAX_LANES-1:0] lane_wen(input int unsigned lane_ptr);
    return MAX_LANES'(1) << lane_ptr;
  endfunction

endpackage

// File: rtl/weight_lane_store.sv
// rtl/weight_lane_store.sv - word store with per-lane write enables and two registered read ports
module weight_lane_store #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES-1:0]        wlane_en,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re1,
  input  logic [AW-1:0]           raddr1,
  output logic [LANES*DATA_W-1:0] rdata1,
  input  logic                    re2,
  input  logic [AW-1:0]           raddr2,
  output logic [LANES*DATA_W-1:0] rdata2
);

  // Contents are deliberately not reset so this can become an SRAM macro wrapper.
  logic [LANES*DATA_W-1:0] mem [DEPTH];

  // Write only the enabled lanes; the other lanes of the word keep their data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (wlane_en[k]) begin
          mem[waddr][k*DATA_W +: DATA_W] <= wdata;
        end
      end
    end
  end

  // Registered reads; non-blocking update of mem gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (re1) begin
      rdata1 <= mem[raddr1];
    end
    if (re2) begin
      rdata2 <= mem[raddr2];
    end
  end

endmodule

// File: rtl/cnn_weight_lane_buffer.sv
// rtl/cnn_weight_lane_buffer.sv - packs a serial weight stream into lane words and serves two read ports
module cnn_weight_lane_buffer
  import cnn_weight_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANES     = DEF_LANES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_WORDS = 50,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    wr_valid,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  output logic                    load_done,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr1,
  input  logic [AW-1:0]           rd_addr2,
  input  logic [AW-1:0]           rd_offset,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] rd_data1,
  output logic [LANES*DATA_W-1:0] rd_data2,
  output logic [1:0]              rd_err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = LANES * DATA_W;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [AW-1:0] WORD_LAST = AW'(NUM_WORDS - 1);
  localparam logic [AW:0]   ADDR_LIM  = (AW+1)'(DEPTH);

  wr_state_t        state;
  logic [AW-1:0]    word_ptr;
  logic [LW-1:0]    lane_ptr;
  logic             wr_fire;
  logic [LANES-1:0] lane_en;

  logic [AW:0]      ea1;
  logic [AW:0]      ea2;
  logic             err1;
  logic             err2;
  logic             ok1;
  logic             ok2;
  logic [WW-1:0]    q1;
  logic [WW-1:0]    q2;

  // A weight dropped alongside load_start must not land, so ready is gated by it.
  assign wr_ready = (state == LOAD) && !load_start;
  assign wr_fire  = wr_valid && wr_ready;
  assign lane_en  = LANES'(lane_wen(32'(lane_ptr)));

  // Write pointers and load FSM; load_done tracks entry into DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      word_ptr  <= '0;
      lane_ptr  <= '0;
      load_done <= 1'b0;
    end else if (load_start) begin
      state     <= LOAD;
      word_ptr  <= '0;
      lane_ptr  <= '0;
      load_done <= 1'b0;
    end else if (wr_fire) begin
      if (lane_ptr == LANE_LAST) begin
        lane_ptr <= '0;
        if (word_ptr == WORD_LAST) begin
          word_ptr  <= '0;
          state     <= DONE;
          load_done <= 1'b1;
        end else begin
          word_ptr <= word_ptr + 1'b1;
        end
      end else begin
        lane_ptr <= lane_ptr + 1'b1;
      end
    end
  end

  // Port 2 adds the bank offset one bit wider so an overflow is caught, not wrapped.
  assign ea1  = {1'b0, rd_addr1};
  assign ea2  = {1'b0, rd_addr2} + {1'b0, rd_offset};
  assign err1 = (ea1 >= ADDR_LIM);
  assign err2 = (ea2 >= ADDR_LIM);

  weight_lane_store #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_store (
    .clk      (clk),
    .we       (wr_fire),
    .waddr    (word_ptr),
    .wlane_en (lane_en),
    .wdata    (wr_data),
    .re1      (rd_en && !err1),
    .raddr1   (ea1[AW-1:0]),
    .rdata1   (q1),
    .re2      (rd_en && !err2),
    .raddr2   (ea2[AW-1:0]),
    .rdata2   (q2)
  );

  // Read status; ok flags mask the unreset store registers to zero after reset or on a range error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 2'b00;
      ok1      <= 1'b0;
      ok2      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_err <= {err2, err1};
        ok1    <= !err1;
        ok2    <= !err2;
      end
    end
  end

  assign rd_data1 = ok1 ? q1 : '0;
  assign rd_data2 = ok2 ? q2 : '0;

endmodule

// File: tb/tb_cnn_weight_lane_buffer.sv
// tb/tb_cnn_weight_lane_buffer.sv - self-checking bench for cnn_weight_lane_buffer
module tb_cnn_weight_lane_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: default geometry
  logic         a_rst = 1'b0, a_load_start = 1'b0, a_wr_valid = 1'b0, a_rd_en = 1'b0;
  logic [15:0]  a_wr_data = '0;
  logic [5:0]   a_rd_addr1 = '0, a_rd_addr2 = '0, a_rd_offset = '0;
  logic         a_wr_ready, a_load_done, a_rd_valid;
  logic [127:0] a_rd_data1, a_rd_data2;
  logic [1:0]   a_rd_err;

  // Instance B: small geometry
  logic         b_rst = 1'b0, b_load_start = 1'b0, b_wr_valid = 1'b0, b_rd_en = 1'b0;
  logic [7:0]   b_wr_data = '0;
  logic [3:0]   b_rd_addr1 = '0, b_rd_addr2 = '0, b_rd_offset = '0;
  logic         b_wr_ready, b_load_done, b_rd_valid;
  logic [31:0]  b_rd_data1, b_rd_data2;
  logic [1:0]   b_rd_err;

  cnn_weight_lane_buffer #(.DATA_W(16), .LANES(8), .DEPTH(64), .NUM_WORDS(50)) dut_a (
    .clk(clk), .rst(a_rst), .load_start(a_load_start), .wr_valid(a_wr_valid),
    .wr_data(a_wr_data), .wr_ready(a_wr_ready), .load_done(a_load_done),
    .rd_en(a_rd_en), .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2), .rd_offset(a_rd_offset),
    .rd_valid(a_rd_valid), .rd_data1(a_rd_data1), .rd_data2(a_rd_data2), .rd_err(a_rd_err)
  );

  cnn_weight_lane_buffer #(.DATA_W(8), .LANES(4), .DEPTH(16), .NUM_WORDS(16)) dut_b (
    .clk(clk), .rst(b_rst), .load_start(b_load_start), .wr_valid(b_wr_valid),
    .wr_data(b_wr_data), .wr_ready(b_wr_ready), .load_done(b_load_done),
    .rd_en(b_rd_en), .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2), .rd_offset(b_rd_offset),
    .rd_valid(b_rd_valid), .rd_data1(b_rd_data1), .rd_data2(b_rd_data2), .rd_err(b_rd_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input logic [127:0] mask);
    n_tests++;
    if (((act ^ exp) & mask) !== 128'd0) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act & mask, exp & mask);
    end
  endtask

  task automatic chk1(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk(name, act, exp, '1);
  endtask

  // Model of instance A: weights indexed by count of accepted weights since load_start.
  logic [15:0]  m_mem   [64][8];
  bit           m_known [64][8];
  int           m_count = 0;
  bit           m_done  = 1'b0;
  bit           e_valid = 1'b0;
  logic [1:0]   e_err   = 2'b00;
  logic [127:0] e_d1 = '0, e_d2 = '0, e_m1 = '1, e_m2 = '1;

  task automatic model_read(input int addr, output logic [127:0] d, output logic [127:0] m,
                            output logic err);
    d = '0;
    m = '0;
    if (addr >= 64) begin
      m   = '1;
      err = 1'b1;
    end else begin
      err = 1'b0;
      for (int k = 0; k < 8; k++) begin
        d[k*16 +: 16] = m_mem[addr][k];
        if (m_known[addr][k]) m[k*16 +: 16] = 16'hFFFF;
      end
    end
  endtask

  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      m_count = 0;
      m_done  = 1'b0;
      e_valid = 1'b0;
      e_err   = 2'b00;
      e_d1    = '0;
      e_d2    = '0;
      e_m1    = '1;
      e_m2    = '1;
    end else begin
      e_valid = a_rd_en;
      if (a_rd_en) begin
        model_read(int'(a_rd_addr1), e_d1, e_m1, e_err[0]);
        model_read(int'(a_rd_addr2) + int'(a_rd_offset), e_d2, e_m2, e_err[1]);
      end
      if (a_load_start) begin
        m_count = 0;
        m_done  = 1'b0;
      end else if (a_wr_valid && !m_done) begin
        m_mem[m_count / 8][m_count % 8]   = a_wr_data;
        m_known[m_count / 8][m_count % 8] = 1'b1;
        m_count++;
        if (m_count == 400) begin
          m_count = 0;
          m_done  = 1'b1;
        end
      end
    end
  end

  // Compare instance A against the model every cycle it is out of reset.
  always @(negedge clk) begin
    if (a_rst === 1'b1) begin
      chk1("a_wr_ready", 128'(a_wr_ready), 128'(!m_done && !a_load_start));
      chk1("a_load_done", 128'(a_load_done), 128'(m_done));
      chk1("a_rd_valid", 128'(a_rd_valid), 128'(e_valid));
      chk1("a_rd_err", 128'(a_rd_err), 128'(e_err));
      chk("a_rd_data1", a_rd_data1, e_d1, e_m1);
      chk("a_rd_data2", a_rd_data2, e_d2, e_m2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [15:0] v);
    a_wr_valid = 1'b1;
    a_wr_data  = v;
    step();
    a_wr_valid = 1'b0;
  endtask

  task automatic a_read(input logic [5:0] a1, input logic [5:0] a2, input logic [5:0] off);
    a_rd_en = 1'b1; a_rd_addr1 = a1; a_rd_addr2 = a2; a_rd_offset = off;
    step();
    a_rd_en = 1'b0;
  endtask

  task automatic a_pulse_start();
    a_load_start = 1'b1;
    step();
    a_load_start = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] v);
    b_wr_valid = 1'b1;
    b_wr_data  = v;
    step();
    b_wr_valid = 1'b0;
  endtask

  task automatic b_read(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] off);
    b_rd_en = 1'b1; b_rd_addr1 = a1; b_rd_addr2 = a2; b_rd_offset = off;
    step();
    b_rd_en = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_w;

    // Reset values while reset is held
    #12;
    chk1("rst_a_load_done", 128'(a_load_done), 128'd0);
    chk1("rst_a_rd_valid", 128'(a_rd_valid), 128'd0);
    chk1("rst_a_rd_err", 128'(a_rd_err), 128'd0);
    chk1("rst_a_rd_data1", a_rd_data1, 128'd0);
    chk1("rst_a_rd_data2", a_rd_data2, 128'd0);
    chk1("rst_b_rd_data1", 128'(b_rd_data1), 128'd0);
    step();
    a_rst = 1'b1;
    b_rst = 1'b1;
    #1;
    chk1("rst_a_wr_ready", 128'(a_wr_ready), 128'd1);

    // Full load of 400 weights, value = index
    for (int i = 0; i < 400; i++) a_write(16'(i));
    chk1("full_load_done", 128'(a_load_done), 128'd1);
    chk1("full_wr_ready", 128'(a_wr_ready), 128'd0);
    a_read(6'd5, 6'd49, 6'd0);
    chk1("w5_lane3", 128'(a_rd_data1[3*16 +: 16]), 128'd43);
    chk1("w49_lane7", 128'(a_rd_data2[7*16 +: 16]), 128'd399);
    for (int w = 0; w < 50; w += 7) begin
      exp_w = '0;
      for (int k = 0; k < 8; k++) exp_w[k*16 +: 16] = 16'(8*w + k);
      a_read(6'(w), 6'(w), 6'd0);
      chk1("packing_p1", a_rd_data1, exp_w);
      chk1("packing_p2", a_rd_data2, exp_w);
    end

    // Port-2 offset, in range and out of range
    a_read(6'd7, 6'd3, 6'd25);
    chk1("off_w28_lane0", 128'(a_rd_data2[15:0]), 128'd224);
    chk1("off_err0", 128'(a_rd_err), 128'd0);
    a_read(6'd7, 6'd60, 6'd10);
    chk1("off_oob_data2", a_rd_data2, 128'd0);
    chk1("off_oob_err", 128'(a_rd_err), 128'd2);
    chk1("off_oob_p1", 128'(a_rd_data1[15:0]), 128'd56);

    // Partial word then restart
    a_pulse_start();
    for (int i = 0; i < 3; i++) a_write(16'hAAAA);
    a_pulse_start();
    for (int i = 0; i < 8; i++) a_write(16'h5555);
    a_read(6'd0, 6'd0, 6'd0);
    chk1("partial_w0", a_rd_data1, {8{16'h5555}});
    for (int i = 0; i < 3; i++) a_write(16'h5555);
    a_read(6'd1, 6'd1, 6'd0);
    chk1("partial_w1", a_rd_data1,
         {16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'h5555, 16'h5555, 16'h5555});

    // Read/write collision on word 2 lane 7
    for (int i = 0; i < 12; i++) a_write(16'h1234);
    a_wr_valid = 1'b1; a_wr_data = 16'h9999;
    a_read(6'd2, 6'd2, 6'd0);
    a_wr_valid = 1'b0;
    chk1("collide_old", a_rd_data1, {16'd23, {7{16'h1234}}});
    a_read(6'd2, 6'd2, 6'd0);
    chk1("collide_new", a_rd_data2, {16'h9999, {7{16'h1234}}});

    // load_start with wr_valid in the same cycle drops the weight
    a_load_start = 1'b1; a_wr_valid = 1'b1; a_wr_data = 16'hDEAD;
    #1;
    chk1("start_drop_ready", 128'(a_wr_ready), 128'd0);
    step();
    a_load_start = 1'b0;
    a_write(16'hBEEF);
    a_read(6'd0, 6'd0, 6'd0);
    chk1("start_drop_w0", a_rd_data1, {{7{16'h5555}}, 16'hBEEF});

    // Asynchronous reset mid-load after 17 weights
    a_pulse_start();
    for (int i = 0; i < 16; i++) a_write(16'h7000 + 16'(i));
    a_wr_valid = 1'b1; a_wr_data = 16'h7010;
    a_read(6'd1, 6'd60, 6'd10);
    a_wr_valid = 1'b0;
    chk1("pre_rst_err", 128'(a_rd_err), 128'd2);
    #3;
    a_rst = 1'b0;
    #1;
    chk1("mid_rst_valid", 128'(a_rd_valid), 128'd0);
    chk1("mid_rst_err", 128'(a_rd_err), 128'd0);
    chk1("mid_rst_data1", a_rd_data1, 128'd0);
    chk1("mid_rst_done", 128'(a_load_done), 128'd0);
    step();
    a_rst = 1'b1;
    a_write(16'h0A0A);
    a_write(16'h0B0B);
    a_read(6'd0, 6'd0, 6'd2);
    chk1("reload_w0", a_rd_data1,
         {16'h7007, 16'h7006, 16'h7005, 16'h7004, 16'h7003, 16'h7002, 16'h0B0B, 16'h0A0A});
    chk1("reload_w2", a_rd_data2, {16'h9999, {6{16'h1234}}, 16'h7010});

    // Small geometry: same packing rules
    for (int i = 0; i < 64; i++) b_write(8'(i));
    chk1("b_load_done", 128'(b_load_done), 128'd1);
    chk1("b_wr_ready", 128'(b_wr_ready), 128'd0);
    b_read(4'd0, 4'd5, 4'd10);
    chk1("b_w0", 128'(b_rd_data1), 128'h03020100);
    chk1("b_w15_off", 128'(b_rd_data2), 128'h3F3E3D3C);
    chk1("b_err0", 128'(b_rd_err), 128'd0);
    b_read(4'd1, 4'd10, 4'd6);
    chk1("b_w1", 128'(b_rd_data1), 128'h07060504);
    chk1("b_oob_data2", 128'(b_rd_data2), 128'd0);
    chk1("b_oob_err", 128'(b_rd_err), 128'd2);
    b_load_start = 1'b1;
    step();
    b_load_start = 1'b0;
    for (int i = 0; i < 17; i++) b_write(8'h80 + 8'(i));
    #3;
    b_rst = 1'b0;
    #1;
    chk1("b_rst_valid", 128'(b_rd_valid), 128'd0);
    chk1("b_rst_err", 128'(b_rd_err), 128'd0);
    chk1("b_rst_data1", 128'(b_rd_data1), 128'd0);
    step();
    b_rst = 1'b1;
    b_write(8'hEE);
    b_read(4'd0, 4'd1, 4'd3);
    chk1("b_reload_w0", 128'(b_rd_data1), 128'h838281EE);
    chk1("b_reload_w4", 128'(b_rd_data2), 128'h13121190);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
